// File: rtl/gx4000_pkg.sv
// Shared constants for the GX4000 joystick scheduler: pad bit positions,
// keyboard-matrix rows that carry the pads, FSM encoding and the pad-to-row mapping.
package gx4000_pkg;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_FIRE3 = 6;

    localparam logic [3:0] ROW_PAD_A = 4'd9;
    localparam logic [3:0] ROW_PAD_B = 4'd6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    // Matrix rows are active-low; fire1 and fire2 swap places relative to the pad vector.
    function automatic logic [7:0] pad_to_row(input logic [6:0] pad, input logic fire1_gate);
        logic [7:0] row;
        row    = 8'hFF;
        row[0] = ~pad[JOY_UP];
        row[1] = ~pad[JOY_DOWN];
        row[2] = ~pad[JOY_LEFT];
        row[3] = ~pad[JOY_RIGHT];
        row[4] = ~pad[JOY_FIRE2];
        row[5] = ~(pad[JOY_FIRE1] & fire1_gate);
        row[6] = ~pad[JOY_FIRE3];
        return row;
    endfunction

endpackage

// File: rtl/gx4000_pad_debounce.sv
// Whole-vector debouncer for one 7-bit pad: latches a candidate, counts consecutive
// identical samples and commits the candidate once the count reaches DEBOUNCE_TICKS.
module gx4000_pad_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       sample_en,
    input  logic       compare_en,
    input  logic       commit_en,
    input  logic [6:0] din,
    output logic [6:0] pad
);
    import gx4000_pkg::*;

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_TICKS);

    logic [6:0] cand_q, cand_d;
    logic [6:0] prev_q, prev_d;
    logic [6:0] pad_q, pad_d;
    logic [3:0] cnt_q, cnt_d;

    // NOTE: every always_comb output is given its hold value first so no latch is inferred.
    always_comb begin
        cand_d = cand_q;
        prev_d = prev_q;
        pad_d  = pad_q;
        cnt_d  = cnt_q;
        if (clear) begin
            cand_d = '0;
            prev_d = '0;
            pad_d  = '0;
            cnt_d  = '0;
        end else begin
            if (sample_en) begin
                cand_d = din;
            end
            if (compare_en) begin
                prev_d = cand_q;
                if (cand_q == prev_q) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd1;
                end
            end
            if (commit_en && (cnt_q == CNT_MAX)) begin
                pad_d = cand_q;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            prev_q <= '0;
            pad_q  <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            prev_q <= prev_d;
            pad_q  <= pad_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pad = pad_q;

endmodule

// File: rtl/gx4000_joy_scheduler.sv
// GX4000/Plus joystick sampling scheduler feeding keyboard matrix rows 9 (pad A) and 6 (pad B).
// Optional autofire on fire1 is built when GX4000_AUTOFIRE_EN is defined.
module gx4000_joy_scheduler #(
    parameter int unsigned SAMPLE_DIV     = 64000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned AUTOFIRE_DIV   = 8
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       plus_mode,
    input  logic [6:0] joy1,
    input  logic [6:0] joy2,
    input  logic       joy_swap,
    input  logic [3:0] kbd_row,
    input  logic       autofire_en,
    output logic [7:0] row_data,
    output logic       row_hit,
    output logic [6:0] pad_a,
    output logic [6:0] pad_b,
    output logic       tick
);
    import gx4000_pkg::*;

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       row_data_q, row_data_d;
    logic             row_hit_q, row_hit_d;
    logic             fire1_gate;
    logic             clear, sample_en, compare_en, commit_en;
    logic [6:0]       din_a, din_b;

    always_comb begin
        div_d   = '0;
        tick_d  = 1'b0;
        state_d = ST_IDLE;
        if (plus_mode) begin
            if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
                tick_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            case (state_q)
                ST_IDLE:    state_d = tick_q ? ST_SAMPLE : ST_IDLE;
                ST_SAMPLE:  state_d = ST_COMPARE;
                ST_COMPARE: state_d = ST_COMMIT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    assign clear      = ~plus_mode;
    assign sample_en  = plus_mode && (state_q == ST_SAMPLE);
    assign compare_en = plus_mode && (state_q == ST_COMPARE);
    assign commit_en  = plus_mode && (state_q == ST_COMMIT);
    assign din_a      = joy_swap ? joy2 : joy1;
    assign din_b      = joy_swap ? joy1 : joy2;

    gx4000_pad_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .clear(clear), .sample_en(sample_en),
        .compare_en(compare_en), .commit_en(commit_en), .din(din_a), .pad(pad_a)
    );

    gx4000_pad_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .clear(clear), .sample_en(sample_en),
        .compare_en(compare_en), .commit_en(commit_en), .din(din_b), .pad(pad_b)
    );

`ifdef GX4000_AUTOFIRE_EN
    localparam int unsigned AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic [AF_W-1:0] af_cnt_q, af_cnt_d;
    logic            af_tog_q, af_tog_d;

    // The toggle idles high so fire1 passes untouched whenever autofire is off.
    always_comb begin
        af_cnt_d = af_cnt_q;
        af_tog_d = af_tog_q;
        if (!plus_mode || !autofire_en) begin
            af_cnt_d = '0;
            af_tog_d = 1'b1;
        end else if (tick_q) begin
            if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
                af_cnt_d = '0;
                af_tog_d = ~af_tog_q;
            end else begin
                af_cnt_d = af_cnt_q + AF_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q <= '0;
            af_tog_q <= 1'b1;
        end else begin
            af_cnt_q <= af_cnt_d;
            af_tog_q <= af_tog_d;
        end
    end

    assign fire1_gate = autofire_en ? af_tog_q : 1'b1;
`else
    logic unused_autofire;
    assign unused_autofire = autofire_en ^ (AUTOFIRE_DIV == 0);
    assign fire1_gate      = 1'b1;
`endif

    always_comb begin
        row_data_d = 8'hFF;
        row_hit_d  = 1'b0;
        if (plus_mode) begin
            if (kbd_row == ROW_PAD_A) begin
                row_data_d = pad_to_row(pad_a, fire1_gate);
                row_hit_d  = 1'b1;
            end else if (kbd_row == ROW_PAD_B) begin
                row_data_d = pad_to_row(pad_b, fire1_gate);
                row_hit_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            state_q    <= ST_IDLE;
            row_data_q <= 8'hFF;
            row_hit_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            row_data_q <= row_data_d;
            row_hit_q  <= row_hit_d;
        end
    end

    // Dropping plus_mode must release the matrix in the same cycle, ahead of the registers.
    assign row_data = plus_mode ? row_data_q : 8'hFF;
    assign row_hit  = plus_mode & row_hit_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_gx4000_joy_scheduler.sv
// Self-checking bench for gx4000_joy_scheduler: directed scenarios plus randomized traffic,
// all compared every cycle against a tick-level behavioural model of sampling and debounce.
module tb_gx4000_joy_scheduler;

    localparam int SD  = 4;
    localparam int DEB = 3;
    localparam int AF  = 2;

    logic       clk_sys     = 1'b0;
    logic       reset_n     = 1'b0;
    logic       plus_mode   = 1'b0;
    logic [6:0] joy1        = '0;
    logic [6:0] joy2        = '0;
    logic       joy_swap    = 1'b0;
    logic [3:0] kbd_row     = '0;
    logic       autofire_en = 1'b0;
    logic [7:0] row_data;
    logic       row_hit;
    logic [6:0] pad_a;
    logic [6:0] pad_b;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;

    gx4000_joy_scheduler #(
        .SAMPLE_DIV(SD), .DEBOUNCE_TICKS(DEB), .AUTOFIRE_DIV(AF)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
        .joy1(joy1), .joy2(joy2), .joy_swap(joy_swap), .kbd_row(kbd_row),
        .autofire_en(autofire_en), .row_data(row_data), .row_hit(row_hit),
        .pad_a(pad_a), .pad_b(pad_b), .tick(tick)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Ticks fall every SD enabled cycles; each tick's sample is taken two cycles after the
    // tick and a commit becomes visible four cycles after it. A pad commits when the last
    // DEB samples taken since the last clear are all identical.
    int         m_en = 0;
    int         m_af = 0;
    logic [6:0] m_pad_a = '0;
    logic [6:0] m_pad_b = '0;
    logic [7:0] m_row = 8'hFF;
    logic       m_hit = 1'b0;
    logic [6:0] ha [DEB];
    logic [6:0] hb [DEB];
    int         n_hist = 0;

    function automatic logic [7:0] row_of(input logic [6:0] p, input logic gate);
        logic [7:0] r;
        r[0] = ~p[0];
        r[1] = ~p[1];
        r[2] = ~p[2];
        r[3] = ~p[3];
        r[4] = ~p[5];
        r[5] = ~(p[4] & gate);
        r[6] = ~p[6];
        r[7] = 1'b1;
        return r;
    endfunction

    function automatic logic all_same(input logic [6:0] h [DEB]);
        for (int i = 1; i < DEB; i++) if (h[i] != h[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_tick();
        return (m_en > 0) && (m_en % SD == 0);
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        logic gate;
        logic tick_before;
        if (!reset_n) begin
            m_en = 0; m_af = 0; n_hist = 0;
            m_pad_a = '0; m_pad_b = '0; m_row = 8'hFF; m_hit = 1'b0;
        end else if (!plus_mode) begin
            m_en = 0; m_af = 0; n_hist = 0;
            m_pad_a = '0; m_pad_b = '0; m_row = 8'hFF; m_hit = 1'b0;
        end else begin
            tick_before = m_tick();
`ifdef GX4000_AUTOFIRE_EN
            gate = autofire_en ? ((m_af / AF) % 2 == 0) : 1'b1;
`else
            gate = 1'b1;
`endif
            if (kbd_row == 4'd9)      m_row = row_of(m_pad_a, gate);
            else if (kbd_row == 4'd6) m_row = row_of(m_pad_b, gate);
            else                      m_row = 8'hFF;
            m_hit = (kbd_row == 4'd9) || (kbd_row == 4'd6);
            m_en++;
            if (m_en >= SD + 2 && (m_en - 2) % SD == 0) begin
                for (int i = DEB - 1; i > 0; i--) begin
                    ha[i] = ha[i-1];
                    hb[i] = hb[i-1];
                end
                ha[0] = joy_swap ? joy2 : joy1;
                hb[0] = joy_swap ? joy1 : joy2;
                if (n_hist < DEB) n_hist++;
            end
            if (m_en >= SD + 4 && (m_en - 4) % SD == 0 && n_hist == DEB) begin
                if (all_same(ha)) m_pad_a = ha[0];
                if (all_same(hb)) m_pad_b = hb[0];
            end
            if (!autofire_en) m_af = 0;
            else if (tick_before) m_af++;
        end
    end

    always @(negedge clk_sys) begin
        check("tick", tick, m_tick());
        check("pad_a", pad_a, m_pad_a);
        check("pad_b", pad_b, m_pad_b);
        check("row_data", row_data, plus_mode ? m_row : 8'hFF);
        check("row_hit", row_hit, plus_mode & m_hit);
    end

    // ---------------- stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk_sys);
    endtask

    function automatic logic [6:0] pick_joy();
        case ($urandom_range(0, 6))
            0: return 7'h00;
            1: return 7'h01;
            2: return 7'h10;
            3: return 7'h20;
            4: return 7'h04;
            5: return 7'h7F;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        int flips;
        logic last_b5;
        edges(2);
        at_neg();
        check("reset_row_data", row_data, 8'hFF);
        check("reset_row_hit", row_hit, 1'b0);
        check("reset_pad_a", pad_a, 7'h00);
        check("reset_tick", tick, 1'b0);
        edges(1);
        reset_n = 1'b1;
        edges(1);
        plus_mode = 1'b1;
        joy1      = 7'h01;
        kbd_row   = 4'd9;

        // Third tick's commit lands on the 16th enabled edge.
        edges(15);
        at_neg();
        check("pad_a_before_commit", pad_a, 7'h00);
        edges(1);
        at_neg();
        check("pad_a_commit", pad_a, 7'h01);
        edges(1);
        at_neg();
        check("row9_up", row_data, 8'hFE);
        check("row9_hit", row_hit, 1'b1);

        // One-tick glitch on fire1 must never commit.
        joy1 = 7'h10;
        edges(1);
        joy1 = 7'h01;
        edges(20);
        at_neg();
        check("glitch_pad_a", pad_a, 7'h01);
        check("glitch_row", row_data, 8'hFE);

        // Swapped pads.
        joy1     = 7'h20;
        joy2     = 7'h04;
        joy_swap = 1'b1;
        edges(6 * SD);
        at_neg();
        check("swap_pad_a", pad_a, 7'h04);
        check("swap_pad_b", pad_b, 7'h20);
        kbd_row = 4'd6;
        edges(1);
        at_neg();
        check("row6_fire2", row_data, 8'hEF);
        check("row6_hit", row_hit, 1'b1);
        kbd_row = 4'd9;
        edges(1);
        at_neg();
        check("row9_left", row_data, 8'hFB);

        // Non-pad row: registered, so the old row persists for one cycle.
        kbd_row = 4'd5;
        check("row5_latency", row_data, 8'hFB);
        edges(1);
        at_neg();
        check("row5_data", row_data, 8'hFF);
        check("row5_hit", row_hit, 1'b0);
        kbd_row = 4'd9;

        // plus_mode dropped while the FSM is in COMPARE.
        edges(2);
        while ((m_en - 2) % SD != 0) edges(1);
        plus_mode = 1'b0;
        #1;
        check("drop_row_data", row_data, 8'hFF);
        check("drop_row_hit", row_hit, 1'b0);
        check("drop_pad_a_same_cycle", pad_a, 7'h04);
        edges(1);
        at_neg();
        check("drop_pad_a", pad_a, 7'h00);
        check("drop_pad_b", pad_b, 7'h00);
        for (int i = 0; i < 3 * SD; i++) begin
            edges(1);
            check("no_tick_low", tick, 1'b0);
        end
        plus_mode = 1'b1;
        edges(SD - 1);
        at_neg();
        check("first_tick_early", tick, 1'b0);
        edges(1);
        at_neg();
        check("first_tick", tick, 1'b1);

        // Async reset in COMMIT with a pad committed.
        joy1     = 7'h7F;
        joy_swap = 1'b0;
        edges(6 * SD);
        at_neg();
        check("all_pad_a", pad_a, 7'h7F);
        edges(1);
        while ((m_en - 3) % SD != 0) edges(1);
        reset_n = 1'b0;
        #1;
        check("areset_pad_a", pad_a, 7'h00);
        check("areset_row", row_data, 8'hFF);
        check("areset_hit", row_hit, 1'b0);
        check("areset_tick", tick, 1'b0);
        edges(2);
        reset_n = 1'b1;

`ifdef GX4000_AUTOFIRE_EN
        joy1        = 7'h10;
        kbd_row     = 4'd9;
        autofire_en = 1'b1;
        edges(6 * SD);
        at_neg();
        check("af_pad_a", pad_a, 7'h10);
        flips   = 0;
        last_b5 = row_data[5];
        for (int i = 0; i < 8 * SD; i++) begin
            edges(1);
            if (row_data[5] !== last_b5) flips++;
            last_b5 = row_data[5];
            check("af_pad_a_const", pad_a, 7'h10);
        end
        check("af_flips", 32'(flips >= 3), 32'd1);
        autofire_en = 1'b0;
`else
        flips   = 0;
        last_b5 = 1'b0;
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            edges(1);
            reset_n = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 11) == 0) joy1 = pick_joy();
            if ($urandom_range(0, 11) == 0) joy2 = pick_joy();
            if ($urandom_range(0, 40) == 0) joy_swap = ~joy_swap;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: kbd_row = 4'd9;
                    1: kbd_row = 4'd6;
                    2: kbd_row = 4'd5;
                    default: kbd_row = 4'($urandom);
                endcase
            end
            if (plus_mode && $urandom_range(0, 149) == 0) plus_mode = 1'b0;
            else if (!plus_mode && $urandom_range(0, 7) == 0) plus_mode = 1'b1;
            if ($urandom_range(0, 99) == 0) autofire_en = ~autofire_en;
        end
        reset_n = 1'b1;
        edges(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
